demux1_4_stream: RTL



---
 rtl/demux1_4_stream.sv | 113 +++++++++++
 1 files changed

// File: rtl/demux1_4_stream.sv
// -----------------------------------------------------------------------------
// demux1_4_stream
//
// Registered 1-to-4 stream demultiplexer. One input stream is steered to one
// of four output channels. Each channel owns a one-entry output register with
// its own valid/ready handshake, so a stalled consumer only blocks beats that
// are headed for its own channel.
//
// Optional feature (compile-time macro DEMUX_AUTO_EN):
//   Adds the auto_mode input and a 2-bit round-robin pointer. With
//   auto_mode=1 the destination is the pointer (in_sel is ignored) and the
//   pointer advances on every accepted beat, wrapping 3->0. With auto_mode=0
//   the destination is in_sel and the pointer holds. Without the macro there
//   is no auto_mode port and no pointer.
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst_n      in   1         synchronous reset, active-low
//   in_data    in   WIDTH     input beat
//   in_sel     in   2         destination channel of the current beat
//   in_valid   in   1         input beat present
//   in_ready   out  1         beat for the current destination can be taken
//   out_data   out  4*WIDTH   channel i data in bits [i*WIDTH +: WIDTH]
//   out_valid  out  4         channel i holds a beat
//   out_ready  in   4         channel i consumer accepts its beat
//   auto_mode  in   1         round-robin enable (DEMUX_AUTO_EN only)
// -----------------------------------------------------------------------------
module demux1_4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX_AUTO_EN
    ,
    input  logic               auto_mode
`endif
);

    localparam int NUM_CH = 4;

    logic [1:0]       dest;
    logic             accept;
    logic [WIDTH-1:0] data_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q;

`ifdef DEMUX_AUTO_EN
    logic [1:0] ptr_q;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise a latch is inferred; here the single assignment covers it.
    always_comb begin
        dest = auto_mode ? ptr_q : in_sel;
    end

    // The pointer only moves on an accepted beat in auto mode, so a stall
    // keeps it on the blocked channel and toggling auto_mode leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (auto_mode && accept) begin
            ptr_q <= ptr_q + 2'd1;   // natural 2-bit wrap 3 -> 0
        end
    end
`else
    assign dest = in_sel;
`endif

    // A channel can take a new beat when it is empty or when its current beat
    // leaves this same edge; that lets a channel with a ready consumer run at
    // one beat per cycle. Reset blocks acceptance so a beat offered during
    // reset is dropped rather than half-loaded.
    assign in_ready = rst_n & (~valid_q[dest] | out_ready[dest]);
    assign accept   = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register, independent of order.
    // NOTE: the data registers are reset too, because out_data must read 0
    // after reset rather than whatever the flops powered up with.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && (dest == 2'(i))) begin
                    // Load wins over drain: the consumer takes the old beat
                    // while the new one is written, and valid stays high.
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (valid_q[i] && out_ready[i]) begin
                    // Data is left in place; only the valid flag drops.
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign out_valid = valid_q;

endmodule
